// File: rtl/decimate_pkg.sv
// Shared defaults, derived widths and mode encodings for the decimator.
package decimate_pkg;

  localparam int ADC_WIDTH_DEF = 14;
  localparam int MAX_LOG2_DEF  = 4;
  localparam int LOG2_W_DEF    = 3;

  // Accumulator width: a full frame of 2^max_log2 samples adds max_log2 bits
  // of growth, so the sum of any frame is always representable.
  function automatic int acc_width(input int adc_width, input int max_log2);
    return adc_width + max_log2;
  endfunction

  localparam int ACC_WIDTH_DEF = acc_width(ADC_WIDTH_DEF, MAX_LOG2_DEF);

  // avg_mode encoding.
  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_AVG  = 1'b1;

endpackage

// File: rtl/decimate_acc.sv
// Frame accumulator for average mode: sign-extends each accepted sample,
// sums it into the running frame total and exposes the floor-rounded mean
// of (total + current sample) so the top can register it on the last sample.
module decimate_acc
  import decimate_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int MAX_LOG2  = MAX_LOG2_DEF,
  parameter int LOG2_W    = LOG2_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [ADC_WIDTH-1:0] sample_in,
  input  logic                        sample_vld,
  input  logic                        frame_end,
  input  logic        [LOG2_W-1:0]    exp_sh,
  output logic signed [ADC_WIDTH-1:0] mean_out
);

  localparam int ACC_W = acc_width(ADC_WIDTH, MAX_LOG2);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;

  // Sum including the current sample, its arithmetic-shift mean, and the next accumulator value.
  always_comb begin
    // NOTE: every variable assigned here gets a value on every path (defaults first), so no latch is inferred.
    sample_ext = {{MAX_LOG2{sample_in[ADC_WIDTH-1]}}, sample_in};
    sum        = acc_q + sample_ext;
    // >>> on a signed operand rounds toward minus infinity; the mean of a
    // frame always fits back into ADC_WIDTH bits, so truncation is exact.
    mean_out   = ADC_WIDTH'(sum >>> exp_sh);
    acc_d      = acc_q;
    if (sample_vld) begin
      acc_d = frame_end ? '0 : sum;
    end
  end

  // Accumulator register, cleared by reset and at every frame boundary.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/decimate_n.sv
// Power-of-two decimator: counts frames of M = 2^dec_log2 valid samples and
// emits either the first sample (pick mode) or the floor mean (average mode)
// of each frame, one cycle after the deciding sample, with a one-cycle strobe.
// Exponent and mode are only reloaded in reset and on a frame wrap so a
// frame in flight never changes length or mode. LOG2_W must be wide enough
// to hold MAX_LOG2.
module decimate_n
  import decimate_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int MAX_LOG2  = MAX_LOG2_DEF,
  parameter int LOG2_W    = LOG2_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [ADC_WIDTH-1:0] adc_data_in,
  input  logic                        adc_valid_in,
  input  logic        [LOG2_W-1:0]    dec_log2,
  input  logic                        avg_mode,
  output logic signed [ADC_WIDTH-1:0] adc_data_out,
  output logic                        adc_valid_out
);

  logic        [MAX_LOG2-1:0]  cnt_q,       cnt_d;
  logic        [LOG2_W-1:0]    exp_q,       exp_d;
  logic                        mode_q,      mode_d;
  logic signed [ADC_WIDTH-1:0] data_out_q,  data_out_d;
  logic                        valid_out_q, valid_out_d;

  logic        [LOG2_W-1:0]    exp_cfg;
  logic        [MAX_LOG2-1:0]  last_cnt;
  logic                        frame_end;
  logic signed [ADC_WIDTH-1:0] mean;

  // Clamp the requested exponent and derive the final phase of the active frame.
  always_comb begin
    exp_cfg   = (dec_log2 > LOG2_W'(MAX_LOG2)) ? LOG2_W'(MAX_LOG2) : dec_log2;
    // M-1 as a mask of exp_q ones; exp_q never exceeds MAX_LOG2.
    last_cnt  = ~({MAX_LOG2{1'b1}} << exp_q);
    frame_end = adc_valid_in && (cnt_q == last_cnt);
  end

  decimate_acc #(
    .ADC_WIDTH (ADC_WIDTH),
    .MAX_LOG2  (MAX_LOG2),
    .LOG2_W    (LOG2_W)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (adc_data_in),
    .sample_vld (adc_valid_in),
    .frame_end  (frame_end),
    .exp_sh     (exp_q),
    .mean_out   (mean)
  );

  // Phase counter, config reload on wrap, and output selection per mode.
  always_comb begin
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    mode_d      = mode_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    if (adc_valid_in) begin
      cnt_d = frame_end ? '0 : cnt_q + 1'b1;
      if (frame_end) begin
        exp_d  = exp_cfg;
        mode_d = avg_mode;
      end
      if (mode_q == MODE_PICK && cnt_q == '0) begin
        data_out_d  = adc_data_in;
        valid_out_d = 1'b1;
      end else if (mode_q == MODE_AVG && frame_end) begin
        data_out_d  = mean;
        valid_out_d = 1'b1;
      end
    end
  end

  // Control and output registers; reset abandons any partial frame and loads the config.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      exp_q       <= exp_cfg;
      mode_q      <= avg_mode;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      mode_q      <= mode_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign adc_data_out  = data_out_q;
  assign adc_valid_out = valid_out_q;

endmodule

// File: tb/tb_decimate_n.sv
// Directed bench for decimate_n: expected outputs (value and the cycle the
// strobe must appear on) are queued as samples are driven; a negedge monitor
// pops and compares on every strobe and flags strobes nobody expected.
module tb_decimate_n;

  localparam int W = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [W-1:0]  adc_data_in;
  logic                 adc_valid_in;
  logic        [2:0]    dec_log2;
  logic                 avg_mode;
  logic signed [W-1:0]  adc_data_out;
  logic                 adc_valid_out;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   last_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  decimate_n u_dut (
    .clk           (clk),
    .rst           (rst),
    .adc_data_in   (adc_data_in),
    .adc_valid_in  (adc_valid_in),
    .dec_log2      (dec_log2),
    .avg_mode      (avg_mode),
    .adc_data_out  (adc_data_out),
    .adc_valid_out (adc_valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of input (valid or idle) starting at a falling edge.
  task automatic send(input int d, input logic v = 1'b1);
    @(negedge clk);
    adc_data_in  = W'(d);
    adc_valid_in = v;
    last_cyc     = cyc;
  endtask

  // The sample just driven must produce value d on the following cycle.
  task automatic expect_out(input int d);
    exp_t e;
    e.data = W'(d);
    e.cyc  = last_cyc + 1;
    sb_q.push_back(e);
  endtask

  // Two reset cycles with a valid sample offered (must be dropped), then check outputs.
  task automatic do_reset(input int dl, input logic am);
    @(negedge clk);
    rst          = 1'b1;
    adc_valid_in = 1'b1;
    adc_data_in  = W'(123);
    dec_log2     = 3'(dl);
    avg_mode     = am;
    repeat (2) @(negedge clk);
    checks++;
    assert (adc_data_out === '0) else begin
      errors++;
      $error("FAIL reset_data observed=%0d expected=0", adc_data_out);
    end
    checks++;
    assert (adc_valid_out === 1'b0) else begin
      errors++;
      $error("FAIL reset_valid observed=%b expected=0", adc_valid_out);
    end
    rst          = 1'b0;
    adc_valid_in = 1'b0;
  endtask

  // Output monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (adc_valid_out === 1'b1) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_strobe cycle=%0d observed=%0d expected=no strobe", cyc, adc_data_out);
      end
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        checks++;
        assert (adc_data_out === mon_e.data) else begin
          errors++;
          $error("FAIL out_data cycle=%0d observed=%0d expected=%0d", cyc, adc_data_out, $signed(mon_e.data));
        end
        checks++;
        assert (cyc === mon_e.cyc) else begin
          errors++;
          $error("FAIL out_cycle observed=%0d expected=%0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    adc_data_in  = '0;
    adc_valid_in = 1'b0;
    dec_log2     = '0;
    avg_mode     = 1'b0;

    // Pick, M=2, continuous valid: 10,20,30,40 -> 10, 30.
    do_reset(1, 1'b0);
    send(10); expect_out(10);
    send(20);
    send(30); expect_out(30);
    send(40);

    // Mid-frame exponent change: frame finishes at M=2, next frame M=8,
    // then dec_log2=7 clamps to 4 (M=16) from the frame after.
    send(50); expect_out(50);
    dec_log2 = 3'd3;
    send(60);
    send(1); expect_out(1);
    dec_log2 = 3'd7;
    for (int k = 2; k <= 8; k++) send(k);
    for (int k = 0; k < 16; k++) begin
      send(100 + k);
      if (k == 0) expect_out(100);
    end
    send(300); expect_out(300);

    // Average, M=4: 4,8,-4,-9 -> floor(-1/4) = -1.
    do_reset(2, 1'b1);
    send(4); send(8); send(-4);
    send(-9); expect_out(-1);

    // Average, M=2 floor rounding: (3+4)/2 -> 3, (-3-4)/2 -> -4.
    do_reset(1, 1'b1);
    send(3); send(4); expect_out(3);
    send(-3); send(-4); expect_out(-4);

    // Average, M=16 at both rails: no overflow.
    do_reset(4, 1'b1);
    for (int k = 0; k < 16; k++) send(-8192);
    expect_out(-8192);
    for (int k = 0; k < 16; k++) send(8191);
    expect_out(8191);

    // Pick, M=4 with valid toggling: strobes 8 cycles apart, idle data ignored.
    do_reset(2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      send(i * 10 + 1, 1'b1);
      if (i % 4 == 0) expect_out(i * 10 + 1);
      send(999, 1'b0);
    end

    // Reset mid-frame abandons the partial frame; fresh frame 1,1,1,1 -> 1.
    do_reset(2, 1'b1);
    send(5); send(6); send(7); send(6); expect_out(6);
    send(5); send(6); send(7);
    do_reset(2, 1'b1);
    send(1); send(1); send(1);
    send(1); expect_out(1);

    // M=1 pass-through in both modes, back-to-back strobes.
    do_reset(0, 1'b0);
    send(3); expect_out(3);
    send(-3); expect_out(-3);
    do_reset(0, 1'b1);
    send(7); expect_out(7);
    send(-7); expect_out(-7);

    send(0, 1'b0);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL missing_strobes observed=%0d pending expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
